// File: rtl/chimp_grid_click_decoder.sv
// rtl/chimp_grid_click_decoder.sv - mouse click hit-tester against a COLS x ROWS grid of boxes
// Captures the pointer on a button press and scans one column/row per cycle.
module chimp_grid_click_decoder #(
   parameter  int X_W     = 10,
   parameter  int Y_W     = 9,
   parameter  int COLS    = 8,
   parameter  int ROWS    = 8,
   parameter  int X0      = 17,
   parameter  int Y0      = 8,
   parameter  int CELL_W  = 20,
   parameter  int CELL_H  = 20,
   parameter  int PITCH_X = 37,
   parameter  int PITCH_Y = 28,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic           clk,
   input  logic           iReset,
   input  logic [X_W-1:0] mouseX,
   input  logic [Y_W-1:0] mouseY,
   input  logic           mouseBtn,
   output logic           busy,
   output logic           clickValid,
   output logic           clickHit,
   output logic [CW-1:0]  BoxX,
   output logic [RW-1:0]  BoxY
);

   localparam int N = (COLS > ROWS) ? COLS : ROWS;

   localparam logic [X_W:0] L_X0      = (X_W+1)'(X0);
   localparam logic [Y_W:0] L_Y0      = (Y_W+1)'(Y0);
   localparam logic [X_W:0] L_W_M1    = (X_W+1)'(CELL_W - 1);
   localparam logic [Y_W:0] L_H_M1    = (Y_W+1)'(CELL_H - 1);
   localparam logic [X_W:0] L_PITCH_X = (X_W+1)'(PITCH_X);
   localparam logic [Y_W:0] L_PITCH_Y = (Y_W+1)'(PITCH_Y);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_btn;
   logic [X_W:0]   r_xl;
   logic [Y_W:0]   r_yl;
   logic [X_W:0]   r_base_x;
   logic [Y_W:0]   r_base_y;
   logic [4:0]     r_idx;
   logic           r_col_hit;
   logic           r_row_hit;
   logic [CW-1:0]  r_col;
   logic [RW-1:0]  r_row;

   logic           w_press;
   logic [X_W:0]   w_x_hi;
   logic [Y_W:0]   w_y_hi;
   logic           w_col_in;
   logic           w_row_in;

   assign w_press  = mouseBtn & ~r_btn;
   assign w_x_hi   = r_base_x + L_W_M1;
   assign w_y_hi   = r_base_y + L_H_M1;
   // Index gating keeps boxes past the last column/row from matching while idx runs to N-1.
   assign w_col_in = (r_idx < 5'(COLS)) && (r_xl >= r_base_x) && (r_xl <= w_x_hi);
   assign w_row_in = (r_idx < 5'(ROWS)) && (r_yl >= r_base_y) && (r_yl <= w_y_hi);
   assign busy     = (r_state == S_SCAN);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_press) w_next = S_SCAN;
         S_SCAN:  if (r_idx == 5'(N - 1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (iReset) begin
         r_state    <= S_IDLE;
         r_btn      <= 1'b1;
         r_xl       <= '0;
         r_yl       <= '0;
         r_base_x   <= '0;
         r_base_y   <= '0;
         r_idx      <= '0;
         r_col_hit  <= 1'b0;
         r_row_hit  <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
         clickValid <= 1'b0;
         clickHit   <= 1'b0;
         BoxX       <= '0;
         BoxY       <= '0;
      end else begin
         r_state    <= w_next;
         r_btn      <= mouseBtn;
         clickValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  r_xl      <= {1'b0, mouseX};
                  r_yl      <= {1'b0, mouseY};
                  r_idx     <= '0;
                  r_base_x  <= L_X0;
                  r_base_y  <= L_Y0;
                  r_col_hit <= 1'b0;
                  r_row_hit <= 1'b0;
               end
            end
            S_SCAN: begin
               if (w_col_in) begin
                  r_col_hit <= 1'b1;
                  r_col     <= CW'(r_idx);
               end
               if (w_row_in) begin
                  r_row_hit <= 1'b1;
                  r_row     <= RW'(r_idx);
               end
               r_idx    <= r_idx + 5'd1;
               r_base_x <= r_base_x + L_PITCH_X;
               r_base_y <= r_base_y + L_PITCH_Y;
            end
            S_DONE: begin
               clickValid <= 1'b1;
               clickHit   <= r_col_hit & r_row_hit;
               BoxX       <= r_col_hit ? r_col : '0;
               BoxY       <= r_row_hit ? r_row : '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chimp_grid_click_decoder.sv
// tb/tb_chimp_grid_click_decoder.sv - scoreboard bench: default grid and a small 4x2 grid side by side
// Both instances share stimulus; each has its own expected-result queue and monitor.
module tb_chimp_grid_click_decoder;

   logic       clk = 1'b0;
   logic       iReset;
   logic [9:0] mouseX;
   logic [8:0] mouseY;
   logic       mouseBtn;

   logic       busy1, valid1, hit1;
   logic [2:0] bx1, by1;
   logic       busy2, valid2, hit2;
   logic [1:0] bx2;
   logic [0:0] by2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      bit hit;
      int bx;
      int by;
      int cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   bit   prev_v1 = 1'b0;
   bit   prev_v2 = 1'b0;

   chimp_grid_click_decoder dut1 (
      .clk(clk), .iReset(iReset), .mouseX(mouseX), .mouseY(mouseY), .mouseBtn(mouseBtn),
      .busy(busy1), .clickValid(valid1), .clickHit(hit1), .BoxX(bx1), .BoxY(by1)
   );

   chimp_grid_click_decoder #(
      .COLS(4), .ROWS(2), .X0(0), .Y0(0), .CELL_W(10), .CELL_H(10), .PITCH_X(16), .PITCH_Y(16)
   ) dut2 (
      .clk(clk), .iReset(iReset), .mouseX(mouseX), .mouseY(mouseY), .mouseBtn(mouseBtn),
      .busy(busy2), .clickValid(valid2), .clickHit(hit2), .BoxX(bx2), .BoxY(by2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Geometric hit test: which box (if any) along one axis contains coordinate v.
   function automatic void axis(input int v, input int n, input int org, input int size,
                                input int pitch, output bit in, output int idx);
      in  = 1'b0;
      idx = 0;
      for (int i = 0; i < n; i++) begin
         if (v >= org + i * pitch && v <= org + i * pitch + size - 1) begin
            in  = 1'b1;
            idx = i;
         end
      end
   endfunction

   function automatic exp_t model(input int x, input int y, input int cols, input int rows,
                                  input int x0, input int y0, input int cw, input int ch,
                                  input int px, input int py, input int when);
      exp_t e;
      bit cin, rin;
      int c, r;
      axis(x, cols, x0, cw, px, cin, c);
      axis(y, rows, y0, ch, py, rin, r);
      e.hit = cin & rin;
      e.bx  = c;
      e.by  = r;
      e.cyc = when;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (valid1) begin
         if (q1.size() == 0) chk("dut1_spurious_valid", 1, 0);
         else begin
            e = q1.pop_front();
            chk("dut1_latency_cycle", cyc, e.cyc);
            chk("dut1_hit", int'(hit1), int'(e.hit));
            chk("dut1_boxx", int'(bx1), e.bx);
            chk("dut1_boxy", int'(by1), e.by);
         end
         if (prev_v1) chk("dut1_valid_back_to_back", 1, 0);
      end
      if (valid2) begin
         if (q2.size() == 0) chk("dut2_spurious_valid", 1, 0);
         else begin
            e = q2.pop_front();
            chk("dut2_latency_cycle", cyc, e.cyc);
            chk("dut2_hit", int'(hit2), int'(e.hit));
            chk("dut2_boxx", int'(bx2), e.bx);
            chk("dut2_boxy", int'(by2), e.by);
         end
         if (prev_v2) chk("dut2_valid_back_to_back", 1, 0);
      end
      prev_v1 = valid1;
      prev_v2 = valid2;
   end

   // Called #1 after a posedge with the button released on the previous edge.
   task automatic issue(input int x, input int y, input bit track);
      mouseX   = 10'(x);
      mouseY   = 9'(y);
      mouseBtn = 1'b1;
      if (track) begin
         q1.push_back(model(x, y, 8, 8, 17, 8, 20, 20, 37, 28, cyc + 1 + 8 + 1));
         q2.push_back(model(x, y, 4, 2, 0, 0, 10, 10, 16, 16, cyc + 1 + 4 + 1));
      end
   endtask

   task automatic do_press(input int x, input int y);
      int nb;
      @(posedge clk); #1 mouseBtn = 1'b0;
      @(posedge clk); #1 issue(x, y, 1'b1);
      @(posedge clk); #1 mouseBtn = 1'b0;
      nb = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (busy1) nb++;
         else break;
      end
      chk("dut1_busy_cycles", nb, 8);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int xs[7] = '{20, 290, 36, 37, 54, 600, 50};
      int ys[7] = '{10, 220, 27, 10, 40, 10, 20};
      int x, y;

      iReset = 1'b1; mouseBtn = 1'b0; mouseX = '0; mouseY = '0;
      repeat (3) @(posedge clk);
      #1 iReset = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy1), 0);
      chk("reset_valid", int'(valid1), 0);
      chk("reset_hit", int'(hit1), 0);
      chk("reset_boxx", int'(bx1), 0);
      chk("reset_boxy", int'(by1), 0);
      chk("reset_busy2", int'(busy2), 0);

      for (int i = 0; i < 7; i++) do_press(xs[i], ys[i]);

      // Second press three cycles into a scan is dropped by both instances.
      @(posedge clk); #1 issue(290, 220, 1'b1);
      @(posedge clk); #1 mouseBtn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 mouseBtn = 1'b1;
      @(posedge clk); #1 mouseBtn = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // Reset during the 4th scan cycle aborts the click and clears the outputs.
      @(posedge clk); #1 issue(100, 100, 1'b0);
      @(posedge clk); #1 mouseBtn = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #1 iReset = 1'b1;
      @(posedge clk); #1 iReset = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy1), 0);
      chk("abort_hit", int'(hit1), 0);
      chk("abort_boxx", int'(bx1), 0);
      chk("abort_boxy", int'(by1), 0);
      repeat (12) @(posedge clk);
      #1;
      do_press(54, 40);

      // Button held through reset release must not trigger a click.
      iReset = 1'b1; mouseBtn = 1'b1;
      repeat (2) @(posedge clk);
      #1 iReset = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("held_btn_no_busy", int'(busy1), 0);
      do_press(290, 220);

      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) begin
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 300);
         end else begin
            x = 17 + 37 * $urandom_range(0, 8) + $urandom_range(0, 2) * 19 - 1 + $urandom_range(0, 2);
            y = 8 + 28 * $urandom_range(0, 8) + $urandom_range(0, 2) * 19 - 1 + $urandom_range(0, 2);
         end
         do_press(x, y);
      end

      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("dut1_queue_drained", q1.size(), 0);
      chk("dut2_queue_drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
